// File: rtl/window_3x3_gen_pkg.sv
// Shared sizing defaults and window indexing helpers for the 3x3 window generator.
package window_3x3_gen_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned IMG_W_DEF  = 28;
  localparam int unsigned IMG_H_DEF  = 28;
  localparam int unsigned WIN_K      = 3;
  localparam int unsigned WIN_N      = WIN_K * WIN_K;

  // Flat element index of window position (r,c); r=0 oldest row, c=0 leftmost column.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return WIN_K * r + c;
  endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out bundle between the reshape stage, this block and the MAC stage.
interface window_3x3_gen_if
  import window_3x3_gen_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic                         pi_data_valid;
  logic signed [DATA_W-1:0]     pi_data;
  logic                         po_win_valid;
  logic [WIN_N*DATA_W-1:0]      po_win;
  logic                         po_frame_end;

  modport master (
    output pi_data_valid, pi_data,
    input  po_win_valid, po_win, po_frame_end
  );

  modport slave (
    input  pi_data_valid, pi_data,
    output po_win_valid, po_win, po_frame_end
  );

endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// Enable-gated DEPTH-sample delay line: RAM with a wrapping pointer, read-before-write.
module line_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 28
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_ptr;

  // Storage is not cleared; stale contents are masked by the row counter upstream.
  always_ff @(posedge sys_clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  assign o_data = r_mem[r_ptr];

endmodule

// File: rtl/window_3x3_gen.sv
// Raster pixel stream to 3x3 valid-convolution neighbourhoods using two line buffers.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  window_3x3_gen_if.slave   bus
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] r_col_cnt;
  logic [RW-1:0] r_row_cnt;
  logic [WIN_K-1:0][WIN_K-1:0][DATA_W-1:0] r_win;
  logic [WIN_N*DATA_W-1:0] r_win_out;
  logic                    r_win_valid;
  logic                    r_frame_end;

  logic [DATA_W-1:0] w_lb0;
  logic [DATA_W-1:0] w_lb1;
  logic [WIN_K-1:0][WIN_K-1:0][DATA_W-1:0] w_win_next;
  logic [WIN_N*DATA_W-1:0] w_win_flat;
  logic w_emit;
  logic w_last;

  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_en      (bus.pi_data_valid),
    .i_data    (bus.pi_data),
    .o_data    (w_lb0)
  );

  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_en      (bus.pi_data_valid),
    .i_data    (w_lb0),
    .o_data    (w_lb1)
  );

  // Shift left one column; the new right column is {oldest row .. current pixel}.
  always_comb begin
    w_win_next = r_win;
    w_win_flat = '0;
    for (int unsigned r = 0; r < WIN_K; r++) begin
      for (int unsigned c = 0; c < WIN_K - 1; c++) begin
        w_win_next[r][c] = r_win[r][c + 1];
      end
    end
    w_win_next[0][WIN_K-1] = w_lb1;
    w_win_next[1][WIN_K-1] = w_lb0;
    w_win_next[2][WIN_K-1] = bus.pi_data;
    for (int unsigned r = 0; r < WIN_K; r++) begin
      for (int unsigned c = 0; c < WIN_K; c++) begin
        w_win_flat[DATA_W*win_idx(r, c) +: DATA_W] = w_win_next[r][c];
      end
    end
  end

  assign w_emit = (r_row_cnt >= RW'(2)) && (r_col_cnt >= CW'(2));
  assign w_last = (r_row_cnt == ROW_LAST) && (r_col_cnt == COL_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_col_cnt   <= '0;
      r_row_cnt   <= '0;
      r_win       <= '0;
      r_win_out   <= '0;
      r_win_valid <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_win_valid <= 1'b0;
      r_frame_end <= 1'b0;
      if (bus.pi_data_valid) begin
        r_win <= w_win_next;
        if (r_col_cnt == COL_LAST) begin
          r_col_cnt <= '0;
          r_row_cnt <= (r_row_cnt == ROW_LAST) ? '0 : r_row_cnt + RW'(1);
        end else begin
          r_col_cnt <= r_col_cnt + CW'(1);
        end
        if (w_emit) begin
          r_win_valid <= 1'b1;
          r_win_out   <= w_win_flat;
          r_frame_end <= w_last;
        end
      end
    end
  end

  assign bus.po_win_valid = r_win_valid;
  assign bus.po_win       = r_win_out;
  assign bus.po_frame_end = r_frame_end;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Checks a 4x4 and a 28x28 instance against a frame-array reference model.
module tb_window_3x3_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned WW = 9 * DW;

  logic sys_clk;
  logic sys_rst_n;

  window_3x3_gen_if #(.DATA_W(DW)) b4 ();
  window_3x3_gen_if #(.DATA_W(DW)) b28 ();

  window_3x3_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (b4)
  );

  window_3x3_gen #(.DATA_W(DW), .IMG_W(28), .IMG_H(28)) u_dut28 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (b28)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          obs_v   [2];
  logic          obs_fe  [2];
  logic [WW-1:0] obs_win [2];
  assign obs_v[0]   = b4.po_win_valid;
  assign obs_fe[0]  = b4.po_frame_end;
  assign obs_win[0] = b4.po_win;
  assign obs_v[1]   = b28.po_win_valid;
  assign obs_fe[1]  = b28.po_frame_end;
  assign obs_win[1] = b28.po_win;

  // Reference: the frame as a 2-D array plus a linear pixel index within the frame.
  int            img [2][28][28];
  int            pos [2];
  logic          exp_v    [2];
  logic          exp_fe   [2];
  logic [WW-1:0] exp_hold [2];
  int            n_win [2];
  int            n_fe  [2];
  logic [WW-1:0] win_q [$];

  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack_win(input int id, input int r, input int c);
    logic [WW-1:0] p;
    p = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[DW*(3*i+j) +: DW] = DW'(img[id][r-2+i][c-2+j]);
    return p;
  endfunction

  function automatic logic [WW-1:0] pack_list(input int e [9]);
    logic [WW-1:0] p;
    p = '0;
    for (int i = 0; i < 9; i++) p[DW*i +: DW] = DW'(e[i]);
    return p;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pos[k]      = 0;
      exp_v[k]    = 1'b0;
      exp_fe[k]   = 1'b0;
      exp_hold[k] = '0;
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      n_win[k] = 0;
      n_fe[k]  = 0;
    end
    win_q.delete();
  endtask

  // One cycle: check outputs produced by the previous cycle, then drive and predict.
  task automatic step(input int id, input logic v, input int d);
    int w, h, r, c;
    logic vk;
    @(negedge sys_clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid[%0d]", k), WW'(obs_v[k]), WW'(exp_v[k]));
      chk($sformatf("frame_end[%0d]", k), WW'(obs_fe[k]), WW'(exp_fe[k]));
      chk($sformatf("win[%0d]", k), obs_win[k], exp_hold[k]);
      if (obs_v[k] === 1'b1) begin
        n_win[k]++;
        if (obs_fe[k] === 1'b1) n_fe[k]++;
        if (k == 0) win_q.push_back(obs_win[0]);
      end
    end
    b4.pi_data_valid  = (id == 0) && v;
    b4.pi_data        = DW'(d);
    b28.pi_data_valid = (id == 1) && v;
    b28.pi_data       = DW'(d);
    for (int k = 0; k < 2; k++) begin
      vk = v && (id == k) && sys_rst_n;
      w  = (k == 0) ? 4 : 28;
      h  = w;
      exp_v[k]  = 1'b0;
      exp_fe[k] = 1'b0;
      if (vk) begin
        r = pos[k] / w;
        c = pos[k] % w;
        img[k][r][c] = d;
        if (r >= 2 && c >= 2) begin
          exp_v[k]    = 1'b1;
          exp_fe[k]   = (r == h - 1) && (c == w - 1);
          exp_hold[k] = pack_win(k, r, c);
        end
        pos[k] = (pos[k] + 1) % (w * h);
      end
    end
  endtask

  task automatic rst_pulse(input int cycles);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    b4.pi_data_valid  = 1'b0;
    b28.pi_data_valid = 1'b0;
    model_reset();
    repeat (cycles) step(0, 1'b0, 0);
    sys_rst_n = 1'b1;
  endtask

  task automatic flush();
    repeat (3) step(0, 1'b0, 0);
  endtask

  initial begin
    int e1 [9];
    int e2 [9];
    n_checks = 0;
    n_fail   = 0;
    sys_rst_n = 1'b0;
    b4.pi_data_valid  = 1'b0;
    b4.pi_data        = '0;
    b28.pi_data_valid = 1'b0;
    b28.pi_data       = '0;
    model_reset();
    clear_counts();
    rst_pulse(3);

    // contiguous 0..15
    clear_counts();
    for (int p = 0; p < 16; p++) step(0, 1'b1, p);
    flush();
    chk("t1_windows", WW'(n_win[0]), WW'(4));
    chk("t1_frame_end", WW'(n_fe[0]), WW'(1));

    // valid toggling every cycle
    clear_counts();
    for (int p = 0; p < 16; p++) begin
      step(0, 1'b1, p);
      step(0, 1'b0, 0);
    end
    flush();
    chk("t2_windows", WW'(n_win[0]), WW'(4));
    chk("t2_frame_end", WW'(n_fe[0]), WW'(1));

    // signed pixels
    clear_counts();
    for (int p = 0; p < 16; p++) step(0, 1'b1, -p);
    flush();
    e1 = '{0, -1, -2, -4, -5, -6, -8, -9, -10};
    chk("t3_first_win", (win_q.size() > 0) ? win_q[0] : '0, pack_list(e1));
    chk("t3_windows", WW'(n_win[0]), WW'(4));

    // two back-to-back frames
    clear_counts();
    for (int p = 0; p < 16; p++) step(0, 1'b1, p);
    for (int p = 0; p < 16; p++) step(0, 1'b1, 100 + p);
    flush();
    e2 = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
    chk("t4_windows", WW'(n_win[0]), WW'(8));
    chk("t4_frame_end", WW'(n_fe[0]), WW'(2));
    chk("t4_f2_first_win", (win_q.size() > 4) ? win_q[4] : '0, pack_list(e2));

    // reset mid-frame after pixel 9
    clear_counts();
    for (int p = 0; p < 10; p++) step(0, 1'b1, p);
    rst_pulse(2);
    chk("t5_windows_before", WW'(n_win[0]), WW'(0));
    clear_counts();
    for (int p = 0; p < 16; p++) step(0, 1'b1, p);
    flush();
    chk("t5_windows", WW'(n_win[0]), WW'(4));
    chk("t5_frame_end", WW'(n_fe[0]), WW'(1));

    // 28x28 random signed frame, with a few random idle gaps
    clear_counts();
    for (int p = 0; p < 784; p++) begin
      if ($urandom_range(0, 7) == 0) step(1, 1'b0, 0);
      step(1, 1'b1, int'($urandom_range(0, 18)) - 9);
    end
    flush();
    chk("t6_windows", WW'(n_win[1]), WW'(676));
    chk("t6_frame_end", WW'(n_fe[1]), WW'(1));
    chk("t6_dut4_idle", WW'(n_win[0]), WW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
